// File: rtl/qft_fixed_pkg.sv
// Shared fixed-point definitions for the QFT datapath (sign-magnitude Q1.(W-2)).
// Contents:
//   frac_w    number of fraction bits for a given word width
//   sat_word  all-ones saturation pattern, returned in a 64-bit container
//   div_state_t  state encoding of the sequential divider
package qft_fixed_pkg;

  // Fraction bits of a sign-magnitude Q1.(W-2) word.
  function automatic int frac_w(input int data_w);
    return data_w - 2;
  endfunction

  // All-ones word of data_w bits (low bits of the 64-bit result); caller slices it.
  function automatic logic [63:0] sat_word(input int data_w);
    return (64'd1 << data_w) - 64'd1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_sign_seq_div_step.sv
// One combinational restoring-division step.
// Ports:
//   r       current partial remainder (W bits)
//   d       divisor magnitude, zero-extended to W bits
//   q_bit   resolved quotient bit (1 when r >= d)
//   r_next  (q_bit ? r-d : r) shifted left by one, truncated to W bits
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] r,
  input  logic [W-1:0] d,
  output logic         q_bit,
  output logic [W-1:0] r_next
);

  logic [W:0]   diff_s;
  logic         borrow_s;
  logic [W-1:0] keep_s;

  // Widened subtraction: the extra top bit is the borrow out of r - d.
  assign diff_s   = {1'b0, r} - {1'b0, d};
  assign borrow_s = diff_s[W];
  assign q_bit    = ~borrow_s;

  // Restore on borrow, then shift for the next quotient bit.
  always_comb begin
    keep_s = r;
    if (q_bit) begin
      keep_s = diff_s[W-1:0];
    end else begin
      keep_s = r;
    end
  end

  assign r_next = {keep_s[W-2:0], 1'b0};

endmodule

// File: rtl/divider_sign_seq.sv
// Sequential sign-magnitude fixed-point divider, S = A / B, one quotient bit per cycle.
// Quotient magnitude is floor(|A| * 2^(W-2) / |B|); the sign is A[W-1]^B[W-1].
// A zero divisor or a quotient that does not fit saturates S to all ones with overflow=1.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid, in_ready   operand handshake (accept only in IDLE)
//   A, B                 dividend and divisor, sign-magnitude Q1.(W-2)
//   out_valid, out_ready result handshake; S/overflow held until accepted
//   S, overflow          quotient and overflow flag
module divider_sign_seq
  import qft_fixed_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] S,
  output logic              overflow
);

  localparam int               W        = DATA_W;
  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [63:0]      SAT_FULL = sat_word(DATA_W);
  localparam logic [W-1:0]     SAT_S    = SAT_FULL[W-1:0];
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(frac_w(DATA_W));

  div_state_t       state_r;
  div_state_t       state_next_s;
  logic [W-1:0]     rem_r;
  logic [W-2:0]     q_r;
  logic [W-2:0]     mag_b_r;
  logic             sgn_r;
  logic [CNT_W-1:0] cnt_r;
  logic [W-1:0]     s_r;
  logic             overflow_r;

  logic [W-2:0]     mag_a_s;
  logic [W-2:0]     mag_b_s;
  logic             ovf_s;
  logic             accept_s;
  logic             last_s;
  logic             q_bit_s;
  logic [W-1:0]     rem_next_s;
  logic [W-2:0]     q_next_s;

  assign mag_a_s  = A[W-2:0];
  assign mag_b_s  = B[W-2:0];
  // |A| >= 2|B| means the integer part of the quotient needs more than one bit.
  assign ovf_s    = (mag_b_s == '0) | ({1'b0, mag_a_s} >= {mag_b_s, 1'b0});
  assign accept_s = in_valid & (state_r == IDLE);
  assign last_s   = (cnt_r == '0);
  assign q_next_s = {q_r[W-3:0], q_bit_s};

  div_step #(.W(W)) u_step (
    .r      (rem_r),
    .d      ({1'b0, mag_b_r}),
    .q_bit  (q_bit_s),
    .r_next (rem_next_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = ovf_s ? DONE : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration registers and the held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r      <= '0;
      q_r        <= '0;
      mag_b_r    <= '0;
      sgn_r      <= 1'b0;
      cnt_r      <= '0;
      s_r        <= '0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mag_b_r <= mag_b_s;
            sgn_r   <= A[W-1] ^ B[W-1];
            if (ovf_s) begin
              s_r        <= SAT_S;
              overflow_r <= 1'b1;
            end else begin
              rem_r <= {1'b0, mag_a_s};
              q_r   <= '0;
              cnt_r <= CNT_INIT;
            end
          end
        end
        CALC: begin
          q_r   <= q_next_s;
          rem_r <= rem_next_s;
          if (last_s) begin
            s_r        <= {sgn_r, q_next_s};
            overflow_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          s_r <= s_r;
        end
        default: begin
          s_r <= s_r;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign S         = s_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_divider_sign_seq.sv
module tb_divider_sign_seq;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  divider_sign_seq #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_s;
    logic         exp_ovf;
    int           exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one operand pair for a single accept edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input logic [W-1:0] exp_s);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    check("S_held_after_hs", {16'd0, S}, {16'd0, exp_s});
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    apply(v.a, v.b);
    wait_result(lat);
    check({name, "_lat"}, lat, v.exp_lat);
    check({name, "_S"}, {16'd0, S}, {16'd0, v.exp_s});
    check({name, "_ovf"}, {31'd0, overflow}, {31'd0, v.exp_ovf});
    handshake(v.exp_s);
  endtask

  // Independent integer model of the divider.
  function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t v;
    longint ma;
    longint mb;
    longint q;
    ma = longint'(a[W-2:0]);
    mb = longint'(b[W-2:0]);
    v.a = a;
    v.b = b;
    if (mb == 0 || ma >= 2 * mb) begin
      v.exp_s   = 16'hFFFF;
      v.exp_ovf = 1'b1;
      v.exp_lat = 0;
    end else begin
      q = (ma * 16384) / mb;
      v.exp_s   = {a[W-1] ^ b[W-1], q[14:0]};
      v.exp_ovf = 1'b0;
      v.exp_lat = 15;
    end
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    int lat;
    logic [W-1:0] held_s;
    vec_t rv;
    logic [14:0] ma;
    logic [14:0] mb;

    vecs[0] = '{16'h2000, 16'h4000, 16'h2000, 1'b0, 15};
    vecs[1] = '{16'hA000, 16'h6000, 16'h9555, 1'b0, 15};
    vecs[2] = '{16'h4000, 16'h2000, 16'hFFFF, 1'b1, 0};
    vecs[3] = '{16'h1234, 16'h8000, 16'hFFFF, 1'b1, 0};
    vecs[4] = '{16'h0000, 16'h4000, 16'h0000, 1'b0, 15};
    vecs[5] = '{16'h8000, 16'h4000, 16'h8000, 1'b0, 15};
    vecs[6] = '{16'h0001, 16'h7FFF, 16'h0000, 1'b0, 15};
    vecs[7] = '{16'h3FFF, 16'h2000, 16'h7FFE, 1'b0, 15};
    vecs[8] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b1, 0};
    vecs[9] = '{16'hC000, 16'hC000, 16'h4000, 1'b0, 15};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_S", {16'd0, S}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Result held while out_ready stays low; new operands ignored.
    apply(16'h7FFF, 16'h4000);
    wait_result(lat);
    check("hold_lat", lat, 15);
    check("hold_S", {16'd0, S}, 32'h7FFF);
    held_s = S;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = 16'h1000;
      B = 16'h4000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_S_stable", {16'd0, S}, {16'd0, held_s});
    end
    in_valid = 1'b0;
    handshake(16'h7FFF);
    @(posedge clk);
    #1;
    check("hold_no_stray_accept", {31'd0, out_valid}, 32'd0);

    // Reset in the 6th CALC cycle aborts the operation.
    apply(16'hA000, 16'h6000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_S", {16'd0, S}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after_abort", vecs[0]);

    // Random scoreboard, half biased towards non-overflow operands.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        mb = 15'($urandom_range(1, 32767));
        ma = 15'($urandom_range(0, (2 * int'(mb) - 1 > 32767) ? 32767 : 2 * int'(mb) - 1));
        rv = model({1'($urandom_range(0, 1)), ma}, {1'($urandom_range(0, 1)), mb});
      end else begin
        rv = model(16'($urandom), 16'($urandom));
      end
      run_vec($sformatf("rand%0d", i), rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
